// File: rtl/sobel_edge_detector_pkg.sv
// Shared constants and helpers for the Sobel edge detector family.
// Contents:
//   SLOT_*      slot indices of the packed 8-neighbour matrix (TL in the MSBs)
//   PART_BITS   width of one unsigned weighted partial sum (max 1020)
//   GRAD_BITS   width of a signed Gx/Gy gradient
//   SUM_BITS    width of |Gx|+|Gy| (max 2040)
//   SAT_MAX     largest magnitude presented downstream
//   abs_grad()  magnitude of a signed gradient
package sobel_edge_detector_pkg;

  localparam int SLOT_TL = 7;
  localparam int SLOT_T  = 6;
  localparam int SLOT_TR = 5;
  localparam int SLOT_ML = 4;
  localparam int SLOT_MR = 3;
  localparam int SLOT_BL = 2;
  localparam int SLOT_B  = 1;
  localparam int SLOT_BR = 0;

  localparam int PART_BITS = 10;
  localparam int GRAD_BITS = 11;
  localparam int SUM_BITS  = 11;
  localparam int SAT_MAX   = 255;

  typedef logic signed [GRAD_BITS-1:0] grad_t;
  typedef logic        [SUM_BITS-1:0]  sum_t;

  // |g| always fits: the most negative reachable gradient is -1020.
  function automatic sum_t abs_grad(input grad_t g);
    return g[GRAD_BITS-1] ? sum_t'(-g) : sum_t'(g);
  endfunction

endpackage

// File: rtl/sobel_edge_detector_kernel.sv
// Combinational 3x3 Sobel kernel over the 8-neighbour matrix (the centre pixel
// has zero weight in both directions, so it is not part of the input).
// Ports:
//   I_PIXEL_MATRIX  packed {TL,T,TR,ML,MR,BL,B,BR}, TL in the MSBs
//   O_GX            (TR+2MR+BR)-(TL+2ML+BL), signed
//   O_GY            (BL+2B+BR)-(TL+2T+TR), signed
module sobel_kernel
  import sobel_edge_detector_pkg::*;
#(
  parameter int P_SUBPIXEL_DEPTH = 8
) (
  input  logic [8*P_SUBPIXEL_DEPTH-1:0] I_PIXEL_MATRIX,
  output grad_t                         O_GX,
  output grad_t                         O_GY
);

  typedef logic [PART_BITS-1:0] part_t;

  function automatic part_t px(input logic [8*P_SUBPIXEL_DEPTH-1:0] m, input int slot);
    return part_t'(m[slot*P_SUBPIXEL_DEPTH +: P_SUBPIXEL_DEPTH]);
  endfunction

  part_t gx_pos, gx_neg, gy_pos, gy_neg;

  always_comb begin
    gx_pos = px(I_PIXEL_MATRIX, SLOT_TR) + (px(I_PIXEL_MATRIX, SLOT_MR) << 1) + px(I_PIXEL_MATRIX, SLOT_BR);
    gx_neg = px(I_PIXEL_MATRIX, SLOT_TL) + (px(I_PIXEL_MATRIX, SLOT_ML) << 1) + px(I_PIXEL_MATRIX, SLOT_BL);
    gy_pos = px(I_PIXEL_MATRIX, SLOT_BL) + (px(I_PIXEL_MATRIX, SLOT_B)  << 1) + px(I_PIXEL_MATRIX, SLOT_BR);
    gy_neg = px(I_PIXEL_MATRIX, SLOT_TL) + (px(I_PIXEL_MATRIX, SLOT_T)  << 1) + px(I_PIXEL_MATRIX, SLOT_TR);
    // Zero-extend by one bit so the subtraction is done in signed 11-bit space.
    O_GX = grad_t'({1'b0, gx_pos}) - grad_t'({1'b0, gx_neg});
    O_GY = grad_t'({1'b0, gy_pos}) - grad_t'({1'b0, gy_neg});
  end

endmodule

// File: rtl/sobel_edge_detector.sv
// Sobel edge detector: 3-stage pipeline producing a saturated gradient
// magnitude and a thresholded edge bit per centre pixel, plus a per-frame
// edge-pixel count.
// Ports:
//   I_CLK, I_RESET             clock, asynchronous active-low reset
//   I_PIXEL_COLUMN/ROW         top-left coordinate of the incoming matrix
//   I_PIXEL_MATRIX(_READY)     packed neighbour matrix and its valid
//   I_THRESHOLD                edge threshold, sampled with the (0,0) matrix
//   O_PIXEL_COLUMN/ROW         centre coordinate of the output pixel
//   O_MAGNITUDE, O_EDGE        saturated |Gx|+|Gy| and magnitude >= threshold
//   O_VALID                    output pixel valid
//   O_EDGE_COUNT, O_FRAME_DONE edge count of the last frame and its update pulse
module sobel_edge_detector
  import sobel_edge_detector_pkg::*;
#(
  parameter int P_FRAME_COLUMNS     = 640,
  parameter int P_FRAME_ROWS        = 480,
  parameter int P_SUBPIXEL_DEPTH    = 8,
  parameter int P_DEFAULT_THRESHOLD = 128,
  parameter int P_FRAME_COLUMN_BITS = $clog2(P_FRAME_COLUMNS),
  parameter int P_FRAME_ROW_BITS    = $clog2(P_FRAME_ROWS),
  parameter int P_MATRIX_BITS       = 8*P_SUBPIXEL_DEPTH,
  parameter int P_COUNT_BITS        = $clog2((P_FRAME_COLUMNS-2)*(P_FRAME_ROWS-2)+1)
) (
  input  logic                           I_CLK,
  input  logic                           I_RESET,
  input  logic [P_FRAME_COLUMN_BITS-1:0] I_PIXEL_COLUMN,
  input  logic [P_FRAME_ROW_BITS-1:0]    I_PIXEL_ROW,
  input  logic [P_MATRIX_BITS-1:0]       I_PIXEL_MATRIX,
  input  logic                           I_PIXEL_MATRIX_READY,
  input  logic [P_SUBPIXEL_DEPTH-1:0]    I_THRESHOLD,
  output logic [P_FRAME_COLUMN_BITS-1:0] O_PIXEL_COLUMN,
  output logic [P_FRAME_ROW_BITS-1:0]    O_PIXEL_ROW,
  output logic [P_SUBPIXEL_DEPTH-1:0]    O_MAGNITUDE,
  output logic                           O_EDGE,
  output logic                           O_VALID,
  output logic [P_COUNT_BITS-1:0]        O_EDGE_COUNT,
  output logic                           O_FRAME_DONE
);

  localparam logic [P_FRAME_COLUMN_BITS-1:0] LAST_COL = P_FRAME_COLUMN_BITS'(P_FRAME_COLUMNS-3);
  localparam logic [P_FRAME_ROW_BITS-1:0]    LAST_ROW = P_FRAME_ROW_BITS'(P_FRAME_ROWS-3);
  localparam logic [P_FRAME_COLUMN_BITS-1:0] COL_ONE  = 1;
  localparam logic [P_FRAME_ROW_BITS-1:0]    ROW_ONE  = 1;
  localparam logic [P_COUNT_BITS-1:0]        CNT_MAX  = '1;

  // Stage 0 (combinational): acceptance, frame markers, kernel
  logic  accept, in_start, in_end;
  grad_t k_gx, k_gy;

  sobel_kernel #(.P_SUBPIXEL_DEPTH(P_SUBPIXEL_DEPTH)) u_kernel (
    .I_PIXEL_MATRIX (I_PIXEL_MATRIX),
    .O_GX           (k_gx),
    .O_GY           (k_gy)
  );

  // NOTE: every always_comb output gets a value on every path (here
  // unconditionally) so no latch can be inferred.
  always_comb begin
    accept   = I_PIXEL_MATRIX_READY && (I_PIXEL_COLUMN <= LAST_COL) && (I_PIXEL_ROW <= LAST_ROW);
    in_start = (I_PIXEL_COLUMN == '0) && (I_PIXEL_ROW == '0);
    in_end   = (I_PIXEL_COLUMN == LAST_COL) && (I_PIXEL_ROW == LAST_ROW);
  end

  // Pipeline state
  logic                           s1_valid, s1_start, s1_end;
  grad_t                          s1_gx, s1_gy;
  logic [P_FRAME_COLUMN_BITS-1:0] s1_col, s2_col;
  logic [P_FRAME_ROW_BITS-1:0]    s1_row, s2_row;
  logic                           s2_valid, s2_start, s2_end;
  sum_t                           s2_sum;
  logic [P_SUBPIXEL_DEPTH-1:0]    threshold_q;
  logic [P_COUNT_BITS-1:0]        edge_count_q;

  // Stage 3 (combinational part): saturation, compare, counter update
  logic [P_SUBPIXEL_DEPTH-1:0] s3_mag;
  logic                        s3_edge;
  logic [P_COUNT_BITS-1:0]     cnt_base, cnt_next;

  always_comb begin
    s3_mag   = (s2_sum > sum_t'(SAT_MAX)) ? P_SUBPIXEL_DEPTH'(SAT_MAX) : s2_sum[P_SUBPIXEL_DEPTH-1:0];
    s3_edge  = (s3_mag >= threshold_q);
    // A frame-start pixel restarts counting, discarding any truncated frame.
    cnt_base = s2_start ? '0 : edge_count_q;
    cnt_next = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + P_COUNT_BITS'(s3_edge);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // stage samples the previous stage's value from before the clock edge.
  // NOTE: the datapath registers are reset as well as the valids, so the
  // coordinate/magnitude outputs read 0 out of reset rather than X.
  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET) begin
      s1_valid <= 1'b0;
      s1_start <= 1'b0;
      s1_end   <= 1'b0;
      s1_gx    <= '0;
      s1_gy    <= '0;
      s1_col   <= '0;
      s1_row   <= '0;
      s2_valid <= 1'b0;
      s2_start <= 1'b0;
      s2_end   <= 1'b0;
      s2_sum   <= '0;
      s2_col   <= '0;
      s2_row   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_gx    <= k_gx;
        s1_gy    <= k_gy;
        s1_col   <= I_PIXEL_COLUMN + COL_ONE;
        s1_row   <= I_PIXEL_ROW + ROW_ONE;
        s1_start <= in_start;
        s1_end   <= in_end;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sum   <= abs_grad(s1_gx) + abs_grad(s1_gy);
        s2_col   <= s1_col;
        s2_row   <= s1_row;
        s2_start <= s1_start;
        s2_end   <= s1_end;
      end
    end
  end

  // Threshold shadow: frozen for the whole frame once the (0,0) matrix is accepted.
  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET) begin
      threshold_q <= P_SUBPIXEL_DEPTH'(P_DEFAULT_THRESHOLD);
    end else if (accept && in_start) begin
      threshold_q <= I_THRESHOLD;
    end
  end

  // Output stage and edge counter
  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET) begin
      O_VALID        <= 1'b0;
      O_PIXEL_COLUMN <= '0;
      O_PIXEL_ROW    <= '0;
      O_MAGNITUDE    <= '0;
      O_EDGE         <= 1'b0;
      O_EDGE_COUNT   <= '0;
      O_FRAME_DONE   <= 1'b0;
      edge_count_q   <= '0;
    end else begin
      O_VALID      <= s2_valid;
      O_FRAME_DONE <= 1'b0;
      if (s2_valid) begin
        O_PIXEL_COLUMN <= s2_col;
        O_PIXEL_ROW    <= s2_row;
        O_MAGNITUDE    <= s3_mag;
        O_EDGE         <= s3_edge;
        if (s2_end) begin
          O_EDGE_COUNT <= cnt_next;
          O_FRAME_DONE <= 1'b1;
          edge_count_q <= '0;
        end else begin
          edge_count_q <= cnt_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_edge_detector.sv
// Directed testbench for sobel_edge_detector (default 640x480 parameters).
module tb_sobel_edge_detector;

  localparam int CB = $clog2(640);
  localparam int RB = $clog2(480);
  localparam int NB = $clog2((640-2)*(480-2)+1);

  logic          I_CLK = 1'b0;
  logic          I_RESET = 1'b0;
  logic [CB-1:0] I_PIXEL_COLUMN = '0;
  logic [RB-1:0] I_PIXEL_ROW = '0;
  logic [63:0]   I_PIXEL_MATRIX = '0;
  logic          I_PIXEL_MATRIX_READY = 1'b0;
  logic [7:0]    I_THRESHOLD = 8'd0;
  logic [CB-1:0] O_PIXEL_COLUMN;
  logic [RB-1:0] O_PIXEL_ROW;
  logic [7:0]    O_MAGNITUDE;
  logic          O_EDGE, O_VALID, O_FRAME_DONE;
  logic [NB-1:0] O_EDGE_COUNT;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int done_cnt = 0;

  logic [63:0] m_flat, m_step, m_sat, m_126, m_128;

  sobel_edge_detector dut (
    .I_CLK                (I_CLK),
    .I_RESET              (I_RESET),
    .I_PIXEL_COLUMN       (I_PIXEL_COLUMN),
    .I_PIXEL_ROW          (I_PIXEL_ROW),
    .I_PIXEL_MATRIX       (I_PIXEL_MATRIX),
    .I_PIXEL_MATRIX_READY (I_PIXEL_MATRIX_READY),
    .I_THRESHOLD          (I_THRESHOLD),
    .O_PIXEL_COLUMN       (O_PIXEL_COLUMN),
    .O_PIXEL_ROW          (O_PIXEL_ROW),
    .O_MAGNITUDE          (O_MAGNITUDE),
    .O_EDGE               (O_EDGE),
    .O_VALID              (O_VALID),
    .O_EDGE_COUNT         (O_EDGE_COUNT),
    .O_FRAME_DONE         (O_FRAME_DONE)
  );

  always #5 I_CLK = ~I_CLK;

  // Event counters sampled mid-cycle, away from the active edge.
  always @(negedge I_CLK) begin
    if (O_VALID) valid_cnt++;
    if (O_FRAME_DONE) done_cnt++;
  end

  function automatic logic [63:0] mk(input logic [7:0] tl, t, tr, ml, mr, bl, b, br);
    return {tl, t, tr, ml, mr, bl, b, br};
  endfunction

  // Presents one matrix for exactly one clock edge; returns 1 time unit after it.
  task automatic send(input int col, input int row, input logic [63:0] m);
    I_PIXEL_COLUMN       = CB'(col);
    I_PIXEL_ROW          = RB'(row);
    I_PIXEL_MATRIX       = m;
    I_PIXEL_MATRIX_READY = 1'b1;
    @(posedge I_CLK); #1;
    I_PIXEL_MATRIX_READY = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin @(posedge I_CLK); #1; end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge I_CLK);
    #1;
    checks++; if (O_VALID !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0d expected 0", O_VALID); end
    checks++; if (O_MAGNITUDE !== 8'd0) begin errors++; $display("FAIL rst_mag: got %0d expected 0", O_MAGNITUDE); end
    checks++; if (O_EDGE_COUNT !== '0) begin errors++; $display("FAIL rst_count: got %0d expected 0", O_EDGE_COUNT); end
    checks++; if (O_FRAME_DONE !== 1'b0) begin errors++; $display("FAIL rst_done: got %0d expected 0", O_FRAME_DONE); end
    @(negedge I_CLK) I_RESET = 1'b1;
    wait_cyc(1);
    checks++; if (O_VALID !== 1'b0) begin errors++; $display("FAIL rst_idle_valid: got %0d expected 0", O_VALID); end
  endtask

  // Flat matrix: zero gradient, and checks the 3-cycle latency exactly.
  task automatic test_flat();
    send(10, 10, m_flat);
    checks++; if (O_VALID !== 1'b0) begin errors++; $display("FAIL flat_lat1: got %0d expected 0", O_VALID); end
    wait_cyc(1);
    checks++; if (O_VALID !== 1'b0) begin errors++; $display("FAIL flat_lat2: got %0d expected 0", O_VALID); end
    wait_cyc(1);
    checks++; if (O_VALID !== 1'b1) begin errors++; $display("FAIL flat_valid: got %0d expected 1", O_VALID); end
    checks++; if (O_MAGNITUDE !== 8'd0) begin errors++; $display("FAIL flat_mag: got %0d expected 0", O_MAGNITUDE); end
    checks++; if (O_EDGE !== 1'b0) begin errors++; $display("FAIL flat_edge: got %0d expected 0", O_EDGE); end
    checks++; if (O_PIXEL_COLUMN !== CB'(11)) begin errors++; $display("FAIL flat_col: got %0d expected 11", O_PIXEL_COLUMN); end
    checks++; if (O_PIXEL_ROW !== RB'(11)) begin errors++; $display("FAIL flat_row: got %0d expected 11", O_PIXEL_ROW); end
    wait_cyc(1);
    checks++; if (O_VALID !== 1'b0) begin errors++; $display("FAIL flat_pulse: got %0d expected 0", O_VALID); end
  endtask

  // Frame 1: threshold 100 captured at (0,0), 37 edge pixels in total.
  task automatic test_frame();
    int v0;
    I_THRESHOLD = 8'd100;
    send(0, 0, m_step);
    wait_cyc(2);
    checks++; if (O_MAGNITUDE !== 8'd120) begin errors++; $display("FAIL step_mag: got %0d expected 120", O_MAGNITUDE); end
    checks++; if (O_EDGE !== 1'b1) begin errors++; $display("FAIL step_edge: got %0d expected 1", O_EDGE); end
    checks++; if (O_PIXEL_COLUMN !== CB'(1)) begin errors++; $display("FAIL step_col: got %0d expected 1", O_PIXEL_COLUMN); end
    checks++; if (O_EDGE_COUNT !== '0) begin errors++; $display("FAIL count_midframe: got %0d expected 0", O_EDGE_COUNT); end
    // Mid-frame threshold change must not take effect.
    I_THRESHOLD = 8'd200;
    send(5, 5, m_step);
    wait_cyc(2);
    checks++; if (O_EDGE !== 1'b1) begin errors++; $display("FAIL thr_hold_edge: got %0d expected 1", O_EDGE); end
    send(1, 1, m_sat);
    wait_cyc(2);
    checks++; if (O_MAGNITUDE !== 8'd255) begin errors++; $display("FAIL sat_mag: got %0d expected 255", O_MAGNITUDE); end
    checks++; if (O_PIXEL_ROW !== RB'(2)) begin errors++; $display("FAIL sat_row: got %0d expected 2", O_PIXEL_ROW); end
    wait_cyc(1);
    checks++; if (O_MAGNITUDE !== 8'd255) begin errors++; $display("FAIL hold_mag: got %0d expected 255", O_MAGNITUDE); end
    // Out-of-range matrices are dropped; the last legal column is accepted.
    v0 = valid_cnt;
    send(638, 5, m_sat);
    send(5, 478, m_sat);
    wait_cyc(4);
    checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL range_drop: got %0d expected %0d", valid_cnt, v0); end
    send(637, 5, m_flat);
    wait_cyc(2);
    checks++; if (O_VALID !== 1'b1) begin errors++; $display("FAIL last_col_valid: got %0d expected 1", O_VALID); end
    checks++; if (O_PIXEL_COLUMN !== CB'(638)) begin errors++; $display("FAIL last_col: got %0d expected 638", O_PIXEL_COLUMN); end
    // Back-to-back stream: 34 more edges among flats, then the frame-end matrix.
    for (int i = 0; i < 68; i++) send(10 + i, 20, (i % 2 == 0) ? m_sat : m_flat);
    send(637, 477, m_flat);
    wait_cyc(1);
    checks++; if (O_FRAME_DONE !== 1'b0) begin errors++; $display("FAIL done_early: got %0d expected 0", O_FRAME_DONE); end
    wait_cyc(1);
    checks++; if (O_FRAME_DONE !== 1'b1) begin errors++; $display("FAIL done_pulse: got %0d expected 1", O_FRAME_DONE); end
    checks++; if (O_EDGE_COUNT !== NB'(37)) begin errors++; $display("FAIL frame_count: got %0d expected 37", O_EDGE_COUNT); end
    checks++; if (O_PIXEL_ROW !== RB'(478)) begin errors++; $display("FAIL end_row: got %0d expected 478", O_PIXEL_ROW); end
    wait_cyc(1);
    checks++; if (O_FRAME_DONE !== 1'b0) begin errors++; $display("FAIL done_width: got %0d expected 0", O_FRAME_DONE); end
    checks++; if (O_EDGE_COUNT !== NB'(37)) begin errors++; $display("FAIL count_hold: got %0d expected 37", O_EDGE_COUNT); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL done_cnt1: got %0d expected 1", done_cnt); end
  endtask

  // Frame 2: threshold 200 captured, truncated frame restart, fresh count.
  task automatic test_next_frame();
    send(0, 0, m_sat);
    wait_cyc(2);
    checks++; if (O_EDGE !== 1'b1) begin errors++; $display("FAIL f2_sat_edge: got %0d expected 1", O_EDGE); end
    send(3, 3, m_step);
    wait_cyc(2);
    checks++; if (O_EDGE !== 1'b0) begin errors++; $display("FAIL f2_thr200_edge: got %0d expected 0", O_EDGE); end
    send(0, 0, m_sat);
    wait_cyc(2);
    checks++; if (O_FRAME_DONE !== 1'b0) begin errors++; $display("FAIL trunc_no_done: got %0d expected 0", O_FRAME_DONE); end
    send(637, 477, m_flat);
    wait_cyc(2);
    checks++; if (O_FRAME_DONE !== 1'b1) begin errors++; $display("FAIL f2_done: got %0d expected 1", O_FRAME_DONE); end
    checks++; if (O_EDGE_COUNT !== NB'(1)) begin errors++; $display("FAIL f2_count: got %0d expected 1", O_EDGE_COUNT); end
    wait_cyc(1);
    checks++; if (done_cnt !== 2) begin errors++; $display("FAIL done_cnt2: got %0d expected 2", done_cnt); end
  endtask

  // Reset with two matrices in flight, then default threshold 128 in effect.
  task automatic test_reset_flush();
    int v0;
    v0 = valid_cnt;
    send(20, 20, m_sat);
    send(21, 20, m_sat);
    I_RESET = 1'b0;
    #1;
    checks++; if (O_EDGE_COUNT !== '0) begin errors++; $display("FAIL flush_count: got %0d expected 0", O_EDGE_COUNT); end
    checks++; if (O_PIXEL_COLUMN !== '0) begin errors++; $display("FAIL flush_col: got %0d expected 0", O_PIXEL_COLUMN); end
    checks++; if (O_PIXEL_ROW !== '0) begin errors++; $display("FAIL flush_row: got %0d expected 0", O_PIXEL_ROW); end
    wait_cyc(2);
    @(negedge I_CLK) I_RESET = 1'b1;
    wait_cyc(4);
    checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL flush_valid: got %0d expected %0d", valid_cnt, v0); end
    checks++; if (O_MAGNITUDE !== 8'd0) begin errors++; $display("FAIL flush_mag: got %0d expected 0", O_MAGNITUDE); end
    // Magnitudes are always even below saturation, so 126/128 bracket 128.
    send(30, 30, m_126);
    wait_cyc(2);
    checks++; if (O_MAGNITUDE !== 8'd126) begin errors++; $display("FAIL m126_mag: got %0d expected 126", O_MAGNITUDE); end
    checks++; if (O_EDGE !== 1'b0) begin errors++; $display("FAIL m126_edge: got %0d expected 0", O_EDGE); end
    send(31, 30, m_128);
    wait_cyc(2);
    checks++; if (O_MAGNITUDE !== 8'd128) begin errors++; $display("FAIL m128_mag: got %0d expected 128", O_MAGNITUDE); end
    checks++; if (O_EDGE !== 1'b1) begin errors++; $display("FAIL m128_edge: got %0d expected 1", O_EDGE); end
  endtask

  initial begin
    m_flat = mk(8'd50, 8'd50, 8'd50, 8'd50, 8'd50, 8'd50, 8'd50, 8'd50);
    m_step = mk(8'd10, 8'd25, 8'd40, 8'd10, 8'd40, 8'd10, 8'd25, 8'd40); // Gx=120, Gy=0
    m_sat  = mk(8'd0, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255);   // Gx=1020, Gy=0
    m_126  = mk(8'd0, 8'd0, 8'd0, 8'd0, 8'd63, 8'd0, 8'd0, 8'd0);        // Gx=126
    m_128  = mk(8'd0, 8'd0, 8'd0, 8'd0, 8'd64, 8'd0, 8'd0, 8'd0);        // Gx=128
    test_reset();
    test_flat();
    test_frame();
    test_next_frame();
    test_reset_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
